ovf_seq_ctrl: RTL

Sequencer for the start / o_ovf / i_ovf overflow handshake. A rising edge on `start` launches one overflow cycle: `o_ovf` stays high for a programmed delay, drops low, waits for downstream acknowledgement, then pulses `i_ovf` together with `o_ovf` to re-arm. The block sits between the control logic that raises `start` and the overflow datapath, and is the producer of the sequence checked by the team's overflow-check assertions.

---
 rtl/ovf_seq_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/ovf_seq_ctrl.sv
// rtl/ovf_seq_ctrl.sv - start/o_ovf/i_ovf overflow handshake sequencer
// A start rise holds o_ovf high for D cycles, drops it until ack, then pulses i_ovf to re-arm.
module ovf_seq_ctrl #(
    parameter int MIN_DLY = 2,
    parameter int MAX_DLY = 20,
    parameter int LOW_MIN = 2,
    parameter int ACK_TO  = 16,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] dly,
    input  logic             ack,
    output logic             o_ovf,
    output logic             i_ovf,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, ARM, DROP, RELOAD} state_t;

    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_DLY);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_DLY);
    localparam logic [CNT_W-1:0] LOW_C = CNT_W'(LOW_MIN);
    localparam logic [CNT_W-1:0] ACK_C = CNT_W'(ACK_TO);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q, start_d;
    logic             o_ovf_q, o_ovf_d;
    logic             i_ovf_q, i_ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             rise;
    logic [CNT_W-1:0] dly_c;

    always_comb begin
        start_d = start;
        rise    = start & ~start_q;
        if (dly < MIN_C)      dly_c = MIN_C;
        else if (dly > MAX_C) dly_c = MAX_C;
        else                  dly_c = dly;

        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = ARM;
                    cnt_d   = dly_c;
                end
            end
            ARM: begin
                if (cnt_q == 1) begin
                    state_d = DROP;
                    cnt_d   = 1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DROP: begin
                // cnt_q is the index of the DROP cycle currently ending; a qualifying ack beats the timeout
                if (ack && cnt_q >= LOW_C) begin
                    state_d = RELOAD;
                    cnt_d   = '0;
                end else if (cnt_q >= ACK_C) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELOAD: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        o_ovf_d = (state_d != DROP);
        i_ovf_d = (state_d == RELOAD);
        done_d  = (state_d == RELOAD);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            o_ovf_q <= 1'b1;
            i_ovf_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            o_ovf_q <= o_ovf_d;
            i_ovf_q <= i_ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign o_ovf = o_ovf_q;
    assign i_ovf = i_ovf_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule
